// File: rtl/rope_pkg.sv
// Shared types and constants for the rope/harpoon controller.
// ROPE_STICKY_EN adds the STUCK state (rope holds at the ceiling).
package rope_pkg;

   localparam int unsigned COORD_W         = 11;
   localparam int unsigned FRAME_CNT_W     = 6;
   localparam int unsigned SCREEN_BOTTOM_Y = 479;
   localparam int unsigned CEILING_Y       = 0;

`ifdef ROPE_STICKY_EN
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXTEND   = 2'd1,
      STUCK    = 2'd2,
      COOLDOWN = 2'd3
   } ropeState_t;
`else
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXTEND   = 2'd1,
      COOLDOWN = 2'd3
   } ropeState_t;
`endif

endpackage

// File: rtl/edge_detect.sv
// Single-bit rising-edge detector with a registered one-clk pulse output.
module edge_detect (
   input  logic clk,
   input  logic resetN,
   input  logic in,
   output logic out
);

   logic inD;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         inD <= 1'b0;
         out <= 1'b0;
      end else begin
         inD <= in;
         out <= in & ~inD;
      end
   end

endmodule

// File: rtl/rope_shot.sv
// Player rope controller: launches a vertical rope from the character centre and
// grows it upward once per frame. ROPE_STICKY_EN holds the rope at the ceiling.
module rope_shot
   import rope_pkg::*;
#(
   parameter int unsigned CHAR_HIGHT      = 32,
   parameter int unsigned CHAR_WIDTH      = 20,
   parameter int unsigned ROPE_SPEED      = 4,
   parameter int unsigned STICK_FRAMES    = 30,
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        firePress,
   input  logic [10:0] charTopLeftX,
   input  logic        bubbleHit,
   input  logic        onN,
   output logic [10:0] ropeTopLeftX,
   output logic [10:0] ropeTopLeftY,
   output logic        ropeActive,
   output logic        ropeDone
);

   localparam logic [COORD_W-1:0]     BOTTOM_Y  = COORD_W'(SCREEN_BOTTOM_Y);
   localparam logic [COORD_W-1:0]     CEIL_Y    = COORD_W'(CEILING_Y);
   localparam logic [COORD_W-1:0]     START_Y   = COORD_W'(SCREEN_BOTTOM_Y - CHAR_HIGHT);
   localparam logic [COORD_W-1:0]     X_OFFSET  = COORD_W'(CHAR_WIDTH / 2);
   localparam logic [COORD_W-1:0]     SPEED_Y   = COORD_W'(ROPE_SPEED);
   localparam logic [FRAME_CNT_W-1:0] COOL_LAST = FRAME_CNT_W'(COOLDOWN_FRAMES - 1);
`ifdef ROPE_STICKY_EN
   localparam logic [FRAME_CNT_W-1:0] STICK_LAST = FRAME_CNT_W'(STICK_FRAMES - 1);
`endif

   // Catch configurations the frame counter or Y arithmetic cannot represent.
   if (ROPE_SPEED == 0 || ROPE_SPEED > 31 || COOLDOWN_FRAMES == 0 || COOLDOWN_FRAMES > 63 ||
       STICK_FRAMES == 0 || STICK_FRAMES > 63 || CHAR_HIGHT > SCREEN_BOTTOM_Y) begin : gBadParam
      $error("rope_shot: parameter out of range");
   end

   ropeState_t             state;
   logic [FRAME_CNT_W-1:0] frameCnt;
   logic                   pending;
   logic                   fireEdge;
   logic                   clearNow_c;

   edge_detect uFireEdge (
      .clk    (clk),
      .resetN (resetN),
      .in     (firePress),
      .out    (fireEdge)
   );

   // Rope clears on a hit (no frame wait), on the ceiling, or when the stick time ends.
   always_comb begin
      clearNow_c = 1'b0;
      case (state)
`ifdef ROPE_STICKY_EN
         EXTEND:  clearNow_c = bubbleHit;
         STUCK:   clearNow_c = bubbleHit || (startOfFrame && (frameCnt == STICK_LAST));
`else
         EXTEND:  clearNow_c = bubbleHit || (startOfFrame && (ropeTopLeftY <= SPEED_Y));
`endif
         default: clearNow_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         frameCnt     <= '0;
         pending      <= 1'b0;
         ropeTopLeftX <= '0;
         ropeTopLeftY <= BOTTOM_Y;
         ropeActive   <= 1'b0;
         ropeDone     <= 1'b0;
      end else begin
         ropeDone <= 1'b0;
         if (onN) begin
            state        <= IDLE;
            frameCnt     <= '0;
            pending      <= 1'b0;
            ropeTopLeftX <= '0;
            ropeTopLeftY <= BOTTOM_Y;
            ropeActive   <= 1'b0;
         end else if (clearNow_c) begin
            state        <= COOLDOWN;
            frameCnt     <= '0;
            pending      <= 1'b0;
            ropeTopLeftY <= BOTTOM_Y;
            ropeActive   <= 1'b0;
            ropeDone     <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (startOfFrame && pending) begin
                     state        <= EXTEND;
                     pending      <= 1'b0;
                     ropeTopLeftX <= charTopLeftX + X_OFFSET;
                     ropeTopLeftY <= START_Y;
                     ropeActive   <= 1'b1;
                  end else if (fireEdge) begin
                     pending <= 1'b1;
                  end
               end
               EXTEND: begin
                  pending <= 1'b0;
                  // Compare before subtracting so Y never wraps below the ceiling.
                  if (startOfFrame) begin
                     if (ropeTopLeftY > SPEED_Y) begin
                        ropeTopLeftY <= ropeTopLeftY - SPEED_Y;
                     end
`ifdef ROPE_STICKY_EN
                     else begin
                        ropeTopLeftY <= CEIL_Y;
                        state        <= STUCK;
                        frameCnt     <= '0;
                     end
`endif
                  end
               end
`ifdef ROPE_STICKY_EN
               STUCK: begin
                  pending <= 1'b0;
                  if (startOfFrame) begin
                     frameCnt <= frameCnt + FRAME_CNT_W'(1);
                  end
               end
`endif
               COOLDOWN: begin
                  pending <= 1'b0;
                  if (startOfFrame) begin
                     if (frameCnt == COOL_LAST) begin
                        state    <= IDLE;
                        frameCnt <= '0;
                     end else begin
                        frameCnt <= frameCnt + FRAME_CNT_W'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifndef ROPE_STICKY_EN
   logic unusedCeil;
   assign unusedCeil = |CEIL_Y;
`endif

endmodule

// File: tb/tb_rope_shot.sv
// Self-checking bench for rope_shot: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rope_shot;

   localparam int CHAR_HIGHT      = 32;
   localparam int CHAR_WIDTH      = 20;
   localparam int ROPE_SPEED      = 4;
   localparam int STICK_FRAMES    = 30;
   localparam int COOLDOWN_FRAMES = 8;

   localparam int M_IDLE  = 0;
   localparam int M_RISE  = 1;
   localparam int M_STUCK = 2;
   localparam int M_COOL  = 3;

   logic        clk          = 1'b0;
   logic        resetN       = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        firePress    = 1'b0;
   logic [10:0] charTopLeftX = '0;
   logic        bubbleHit    = 1'b0;
   logic        onN          = 1'b0;
   logic [10:0] ropeTopLeftX;
   logic [10:0] ropeTopLeftY;
   logic        ropeActive;
   logic        ropeDone;

   int checks     = 0;
   int failures   = 0;
   int donePulses = 0;

   always #5 clk = ~clk;

   rope_shot #(
      .CHAR_HIGHT      (CHAR_HIGHT),
      .CHAR_WIDTH      (CHAR_WIDTH),
      .ROPE_SPEED      (ROPE_SPEED),
      .STICK_FRAMES    (STICK_FRAMES),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .firePress    (firePress),
      .charTopLeftX (charTopLeftX),
      .bubbleHit    (bubbleHit),
      .onN          (onN),
      .ropeTopLeftX (ropeTopLeftX),
      .ropeTopLeftY (ropeTopLeftY),
      .ropeActive   (ropeActive),
      .ropeDone     (ropeDone)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: frames-left countdowns, an armed flag and a one-cycle edge delay.
   int mMode, mX, mY, mFramesLeft;
   bit mActive, mDone, mArmed, mFireLast, mEdgeNew, mEdgeSeen;

   task mClear();
      mY          = 479;
      mActive     = 0;
      mDone       = 1;
      mMode       = M_COOL;
      mFramesLeft = COOLDOWN_FRAMES;
   endtask

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         mMode = M_IDLE; mX = 0; mY = 479; mActive = 0; mDone = 0;
         mArmed = 0; mFireLast = 0; mEdgeNew = 0; mFramesLeft = 0;
      end else begin
         mEdgeSeen = mEdgeNew;
         mEdgeNew  = firePress && !mFireLast;
         mFireLast = firePress;
         mDone     = 0;
         if (onN) begin
            mMode = M_IDLE; mX = 0; mY = 479; mActive = 0; mArmed = 0; mFramesLeft = 0;
         end else begin
            case (mMode)
               M_IDLE: begin
                  if (startOfFrame && mArmed) begin
                     mMode = M_RISE; mArmed = 0; mActive = 1;
                     mX = (int'(charTopLeftX) + CHAR_WIDTH / 2) % 2048;
                     mY = 479 - CHAR_HIGHT;
                  end else if (mEdgeSeen) begin
                     mArmed = 1;
                  end
               end
               M_RISE: begin
                  mArmed = 0;
                  if (bubbleHit) mClear();
                  else if (startOfFrame) begin
                     if (mY > ROPE_SPEED) mY = mY - ROPE_SPEED;
                     else begin
`ifdef ROPE_STICKY_EN
                        mY = 0; mMode = M_STUCK; mFramesLeft = STICK_FRAMES;
`else
                        mClear();
`endif
                     end
                  end
               end
               M_STUCK: begin
                  mArmed = 0;
                  if (bubbleHit) mClear();
                  else if (startOfFrame) begin
                     mFramesLeft--;
                     if (mFramesLeft == 0) mClear();
                  end
               end
               default: begin
                  mArmed = 0;
                  if (startOfFrame) begin
                     mFramesLeft--;
                     if (mFramesLeft == 0) mMode = M_IDLE;
                  end
               end
            endcase
         end
      end
      #1;
      chk("modelX",      int'(ropeTopLeftX), mX);
      chk("modelY",      int'(ropeTopLeftY), mY);
      chk("modelActive", int'(ropeActive),   int'(mActive));
      chk("modelDone",   int'(ropeDone),     int'(mDone));
      if (ropeDone) donePulses++;
   end

   task automatic cyc(input logic s);
      @(negedge clk);
      startOfFrame = s;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         cyc(0); cyc(0); cyc(0); cyc(1);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   int d0;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("resetX", int'(ropeTopLeftX), 0);
      chk("resetY", int'(ropeTopLeftY), 479);
      chk("resetActive", int'(ropeActive), 0);
      chk("resetDone", int'(ropeDone), 0);

      // Fire at X=300; a frame in the same cycle pending sets must not launch
      @(negedge clk);
      resetN = 1'b1; charTopLeftX = 11'd300; firePress = 1'b1;
      cyc(1);
      settle();
      chk("noEarlyLaunch", int'(ropeActive), 0);
      cyc(0); cyc(1);
      settle();
      chk("launchX", int'(ropeTopLeftX), 310);
      chk("launchY", int'(ropeTopLeftY), 447);
      chk("launchActive", int'(ropeActive), 1);
      cyc(0); charTopLeftX = 11'd500; firePress = 1'b0;
      frames(3);
      settle();
      chk("y3Frames", int'(ropeTopLeftY), 435);
      chk("xLatched", int'(ropeTopLeftX), 310);

      // Ceiling
      d0 = donePulses;
      frames(108);
      settle();
      chk("yBeforeCeil", int'(ropeTopLeftY), 3);
      chk("activeBeforeCeil", int'(ropeActive), 1);
`ifdef ROPE_STICKY_EN
      frames(1);
      settle();
      chk("stuckY", int'(ropeTopLeftY), 0);
      chk("stuckActive", int'(ropeActive), 1);
      frames(29);
      settle();
      chk("stuckHoldY", int'(ropeTopLeftY), 0);
      chk("stuckHoldDone", int'(ropeDone), 0);
`endif
      frames(1);
      settle();
      chk("ceilDone", int'(ropeDone), 1);
      chk("ceilActive", int'(ropeActive), 0);
      chk("ceilY", int'(ropeTopLeftY), 479);
      cyc(0);
      settle();
      chk("doneOneClk", int'(ropeDone), 0);
      chk("donePulseCount", donePulses - d0, 1);

      // Fire during cooldown is discarded
      frames(3);
      cyc(0); firePress = 1'b1;
      cyc(0); firePress = 1'b0;
      frames(5);
      frames(2);
      settle();
      chk("cooldownFireIgnored", int'(ropeActive), 0);
      cyc(0); firePress = 1'b1;
      cyc(0); cyc(0); firePress = 1'b0;
      frames(1);
      settle();
      chk("afterCoolLaunch", int'(ropeActive), 1);
      chk("afterCoolX", int'(ropeTopLeftX), 510);

      // Bubble hit together with a frame at Y=423
      frames(6);
      settle();
      chk("yBeforeHit", int'(ropeTopLeftY), 423);
      cyc(0); cyc(0); cyc(0);
      cyc(1); bubbleHit = 1'b1;
      settle();
      chk("hitActive", int'(ropeActive), 0);
      chk("hitY", int'(ropeTopLeftY), 479);
      chk("hitDone", int'(ropeDone), 1);
      cyc(0); bubbleHit = 1'b0;
      frames(9);

      // onN while the rope is up; held key must not relaunch
      cyc(0); firePress = 1'b1;
      cyc(0); cyc(0);
      frames(1);
`ifdef ROPE_STICKY_EN
      frames(117);
      settle();
      chk("reachedStuck", int'(ropeTopLeftY), 0);
`else
      frames(10);
`endif
      cyc(0); onN = 1'b1;
      settle();
      chk("onNActive", int'(ropeActive), 0);
      chk("onNY", int'(ropeTopLeftY), 479);
      chk("onNX", int'(ropeTopLeftX), 0);
      chk("onNDone", int'(ropeDone), 0);
      cyc(0); onN = 1'b0;
      frames(3);
      settle();
      chk("heldNoRelaunch", int'(ropeActive), 0);
      cyc(0); firePress = 1'b0;
      cyc(0); firePress = 1'b1;
      cyc(0); cyc(0);
      frames(1);
      settle();
      chk("repressLaunch", int'(ropeActive), 1);

      // Asynchronous reset mid-flight
      frames(2);
      @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      chk("asyncRstY", int'(ropeTopLeftY), 479);
      chk("asyncRstActive", int'(ropeActive), 0);
      chk("asyncRstX", int'(ropeTopLeftX), 0);
      @(negedge clk);
      resetN = 1'b1; firePress = 1'b0;
      frames(2);
      settle();
      chk("idleAfterReset", int'(ropeActive), 0);

      // Randomized traffic, checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         startOfFrame = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 5) == 0) firePress = ~firePress;
         bubbleHit = ($urandom_range(0, 99) == 0);
         onN       = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) charTopLeftX = 11'($urandom_range(0, 619));
      end
      @(negedge clk);
      startOfFrame = 1'b0; bubbleHit = 1'b0; onN = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
